// File: rtl/lsu_pipelined_pkg.sv
// Shared types and lane helpers for the pipelined load/store unit.
// The helpers work at 64-bit width and callers truncate to their own DATA_W.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } size_e;

   // rd is sized for the widest register index the unit supports (8 bits)
   typedef struct packed {
      logic       we;
      logic [7:0] rd;
      size_e      size;
      logic       is_unsigned;
      logic [2:0] offset;
   } resp_entry_t;

   function automatic logic [7:0] be_mask(size_e size, logic [2:0] offset);
      logic [7:0] m;
      case (size)
         SZ_B:    m = 8'h01;
         SZ_H:    m = 8'h03;
         SZ_W:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << offset;
   endfunction

   function automatic logic [63:0] lane_shift(logic [63:0] data, logic [2:0] offset);
      return data << {offset, 3'b000};
   endfunction

   function automatic logic [63:0] load_format(logic [63:0] data, logic [2:0] offset,
                                               size_e size, logic is_unsigned);
      logic [63:0] s;
      logic [63:0] r;
      s = data >> {offset, 3'b000};
      case (size)
         SZ_B:    r = is_unsigned ? {56'b0, s[7:0]}  : {{56{s[7]}},  s[7:0]};
         SZ_H:    r = is_unsigned ? {48'b0, s[15:0]} : {{48{s[15]}}, s[15:0]};
         SZ_W:    r = is_unsigned ? {32'b0, s[31:0]} : {{32{s[31]}}, s[31:0]};
         default: r = s;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/lsu_pipelined_if.sv
// Memory-side bus of the load/store unit: request channel plus in-order response channel.
interface lsu_pipelined_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  proc_req;
   logic                  we;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   be;
   logic                  mem_rdy;
   logic                  valid;
   logic [DATA_W-1:0]     rdata;

   modport master (output proc_req, we, addr, wdata, be, input mem_rdy, valid, rdata);
   modport slave  (input proc_req, we, addr, wdata, be, output mem_rdy, valid, rdata);
endinterface

// File: rtl/lsu_pipelined_resp_fifo.sv
// In-order FIFO of issued-but-unanswered accesses, with occupancy count.
module lsu_resp_fifo
   import lsu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         push_i,
   input  resp_entry_t                  entry_i,
   input  logic                         pop_i,
   output resp_entry_t                  head_o,
   output logic [$clog2(DEPTH+1)-1:0]   count_o
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH+1);

   resp_entry_t        mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q;
   logic [PTR_W-1:0]   rd_ptr_q;
   logic [CNT_W-1:0]   count_q;

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointers wrap explicitly so DEPTH=1 works with a 1-bit pointer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= entry_i;
            wr_ptr_q <= (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
         end
         if (pop_i)
            rd_ptr_q <= (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
         case ({push_i, pop_i})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/lsu_pipelined.sv
// MEM-stage load/store unit: accepts core ops, issues them through a one-entry issue
// register, tracks outstanding accesses and formats load results in order.
module lsu_pipelined
   import lsu_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int REG_W          = 5,
   parameter int MAX_OUT        = 2,
   parameter int BLOCKING_LOADS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_i,
   input  logic                 we_i,
   input  logic [1:0]           size_i,
   input  logic                 unsigned_i,
   input  logic [ADDR_W-1:0]    addr_i,
   input  logic [DATA_W-1:0]    wdata_i,
   input  logic [REG_W-1:0]     rd_i,
   output logic                 stall_o,
   output logic                 misalign_o,
   lsu_pipelined_if.master      mem,
   output logic                 load_valid_o,
   output logic [DATA_W-1:0]    load_data_o,
   output logic [REG_W-1:0]     load_dest_o
);
   localparam int BE_W  = DATA_W/8;
   localparam int OFF_W = $clog2(BE_W);
   localparam int CNT_W = $clog2(MAX_OUT+1);

   size_e               size;
   logic [2:0]          offset;
   logic                bad;
   logic                handshake, accept, load_pending, pop;
   resp_entry_t         new_entry, head;
   logic [CNT_W-1:0]    count;

   logic                issue_q, we_q, misalign_q, load_valid_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, load_data_q;
   logic [BE_W-1:0]     be_q;
   logic [REG_W-1:0]    load_dest_q;
   resp_entry_t         meta_q;
   logic [CNT_W-1:0]    loads_q;

   assign size   = size_e'(size_i);
   assign offset = 3'(addr_i[OFF_W-1:0]);

   always_comb begin
      bad = 1'b0;
      case (size)
         SZ_H:    bad = addr_i[0];
         SZ_W:    bad = (addr_i[1:0] != 2'b00);
         SZ_D:    bad = (DATA_W != 64) || (addr_i[2:0] != 3'b000);
         default: bad = 1'b0;
      endcase
   end

   assign new_entry = '{we: we_i, rd: 8'(rd_i), size: size, is_unsigned: unsigned_i, offset: offset};

   // Stall deliberately ignores a pop arriving this cycle; freed slots are seen next cycle
   assign handshake    = issue_q && mem.mem_rdy;
   assign load_pending = (issue_q && !meta_q.we) || (loads_q != '0);
   assign stall_o      = req_i && ((issue_q && !handshake)
                                   || ((32'(count) + 32'(issue_q)) >= 32'(MAX_OUT))
                                   || ((BLOCKING_LOADS != 0) && load_pending));
   assign accept       = req_i && !stall_o;
   assign pop          = mem.valid && (count != '0);

   // Issue register refills on the handshake edge so back-to-back ops see no bubble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issue_q    <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         meta_q     <= '0;
         misalign_q <= 1'b0;
      end else begin
         misalign_q <= accept && bad;
         if (accept && !bad) begin
            issue_q <= 1'b1;
            we_q    <= we_i;
            addr_q  <= {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            wdata_q <= DATA_W'(lane_shift(64'(wdata_i), offset));
            be_q    <= BE_W'(be_mask(size, offset));
            meta_q  <= new_entry;
         end else if (handshake) begin
            issue_q <= 1'b0;
         end
      end
   end

   lsu_resp_fifo #(.DEPTH(MAX_OUT)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (handshake),
      .entry_i (meta_q),
      .pop_i   (pop),
      .head_o  (head),
      .count_o (count)
   );

   // Loads in flight drive the blocking-load stall; stores pop without a writeback
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         loads_q      <= '0;
         load_valid_q <= 1'b0;
         load_data_q  <= '0;
         load_dest_q  <= '0;
      end else begin
         case ({handshake && !meta_q.we, pop && !head.we})
            2'b10:   loads_q <= loads_q + CNT_W'(1);
            2'b01:   loads_q <= loads_q - CNT_W'(1);
            default: loads_q <= loads_q;
         endcase
         load_valid_q <= pop && !head.we;
         if (pop && !head.we) begin
            load_data_q <= DATA_W'(load_format(64'(mem.rdata), head.offset, head.size,
                                               head.is_unsigned));
            load_dest_q <= REG_W'(head.rd);
         end
      end
   end

   assign mem.proc_req  = issue_q;
   assign mem.we        = we_q;
   assign mem.addr      = addr_q;
   assign mem.wdata     = wdata_q;
   assign mem.be        = be_q;
   assign misalign_o    = misalign_q;
   assign load_valid_o  = load_valid_q;
   assign load_data_o   = load_data_q;
   assign load_dest_o   = load_dest_q;
endmodule

// File: tb/tb_lsu_pipelined.sv
// Directed bench for lsu_pipelined: a blocking-load instance and a non-blocking instance.
module tb_lsu_pipelined;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   logic        req1, we1, uns1, stall1, mis1, lv1;
   logic [1:0]  size1;
   logic [31:0] addr1, wdata1, ld1;
   logic [4:0]  rd1, dest1;

   logic        req2, we2, uns2, stall2, mis2, lv2;
   logic [1:0]  size2;
   logic [31:0] addr2, wdata2, ld2;
   logic [4:0]  rd2, dest2;

   lsu_pipelined_if #(.ADDR_W(32), .DATA_W(32)) mif1 ();
   lsu_pipelined_if #(.ADDR_W(32), .DATA_W(32)) mif2 ();

   lsu_pipelined dut (
      .clk(clk), .rst(rst), .req_i(req1), .we_i(we1), .size_i(size1), .unsigned_i(uns1),
      .addr_i(addr1), .wdata_i(wdata1), .rd_i(rd1), .stall_o(stall1), .misalign_o(mis1),
      .mem(mif1.master), .load_valid_o(lv1), .load_data_o(ld1), .load_dest_o(dest1)
   );

   lsu_pipelined #(.MAX_OUT(2), .BLOCKING_LOADS(0)) dut_nb (
      .clk(clk), .rst(rst), .req_i(req2), .we_i(we2), .size_i(size2), .unsigned_i(uns2),
      .addr_i(addr2), .wdata_i(wdata2), .rd_i(rd2), .stall_o(stall2), .misalign_o(mis2),
      .mem(mif2.master), .load_valid_o(lv2), .load_data_o(ld2), .load_dest_o(dest2)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic req, input logic we, input logic [1:0] size,
                                input logic uns, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [4:0] rd);
      req1 = req; we1 = we; size1 = size; uns1 = uns; addr1 = addr; wdata1 = wdata; rd1 = rd;
   endtask

   task automatic applyStimulusNb(input logic req, input logic [31:0] addr, input logic [4:0] rd);
      req2 = req; we2 = 1'b0; size2 = 2'b10; uns2 = 1'b0; addr2 = addr; wdata2 = '0; rd2 = rd;
   endtask

   initial begin
      applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
      applyStimulusNb(0, 32'h0, 5'd0);
      mif1.mem_rdy = 0; mif1.valid = 0; mif1.rdata = '0;
      mif2.mem_rdy = 0; mif2.valid = 0; mif2.rdata = '0;
      #12;
      checkOutput("reset_proc_req", mif1.proc_req, 0);
      checkOutput("reset_stall", stall1, 0);
      checkOutput("reset_misalign", mis1, 0);
      checkOutput("reset_load_valid", lv1, 0);
      checkOutput("reset_load_data", ld1, 0);
      tick();
      rst = 0;

      // SW 0x100 with memory not ready for two cycles
      tick();
      applyStimulus(1, 1, 2'b10, 0, 32'h100, 32'hDEADBEEF, 5'd0);
      #1 checkOutput("sw_stall", stall1, 0);
      tick();
      applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
      checkOutput("sw_addr", mif1.addr, 32'h100);
      checkOutput("sw_be", mif1.be, 4'b1111);
      checkOutput("sw_wdata", mif1.wdata, 32'hDEADBEEF);
      checkOutput("sw_we", mif1.we, 1);
      for (int i = 0; i < 3; i++) begin
         checkOutput("sw_proc_req_held", mif1.proc_req, 1);
         if (i == 2) mif1.mem_rdy = 1;
         if (i < 2) tick();
      end
      tick();
      checkOutput("sw_proc_req_drop", mif1.proc_req, 0);
      mif1.valid = 1;
      tick();
      mif1.valid = 0;
      checkOutput("sw_no_load_valid", lv1, 0);
      tick();
      checkOutput("sw_no_load_valid2", lv1, 0);

      // LB 0x103 then LBU 0x103 held off by the blocking load
      applyStimulus(1, 0, 2'b00, 0, 32'h103, 32'h0, 5'd7);
      #1 checkOutput("lb_stall", stall1, 0);
      tick();
      applyStimulus(1, 0, 2'b00, 1, 32'h103, 32'h0, 5'd8);
      #1;
      checkOutput("lb_addr", mif1.addr, 32'h100);
      checkOutput("lbu_blocked", stall1, 1);
      tick();
      mif1.valid = 1; mif1.rdata = 32'h80112233;
      checkOutput("lbu_blocked2", stall1, 1);
      tick();
      mif1.valid = 0;
      checkOutput("lb_valid", lv1, 1);
      checkOutput("lb_data", ld1, 32'hFFFFFF80);
      checkOutput("lb_dest", dest1, 5'd7);
      checkOutput("lbu_unblocked", stall1, 0);
      tick();
      applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
      checkOutput("lb_valid_pulse", lv1, 0);
      checkOutput("lb_data_hold", ld1, 32'hFFFFFF80);
      checkOutput("lbu_proc_req", mif1.proc_req, 1);
      tick();
      mif1.valid = 1;
      tick();
      mif1.valid = 0;
      checkOutput("lbu_valid", lv1, 1);
      checkOutput("lbu_data", ld1, 32'h00000080);
      checkOutput("lbu_dest", dest1, 5'd8);

      // SH 0x102 lane steering
      applyStimulus(1, 1, 2'b01, 0, 32'h102, 32'h0000ABCD, 5'd0);
      tick();
      applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
      checkOutput("sh_wdata", mif1.wdata, 32'hABCD0000);
      checkOutput("sh_be", mif1.be, 4'b1100);
      checkOutput("sh_addr", mif1.addr, 32'h100);
      tick();
      mif1.valid = 1;
      tick();
      mif1.valid = 0;
      checkOutput("sh_no_load_valid", lv1, 0);

      // LW 0x101 misaligned, then D size illegal on a 32-bit bus
      applyStimulus(1, 0, 2'b10, 0, 32'h101, 32'h0, 5'd4);
      #1 checkOutput("lw_mis_stall", stall1, 0);
      tick();
      applyStimulus(1, 0, 2'b11, 0, 32'h100, 32'h0, 5'd4);
      checkOutput("lw_misalign", mis1, 1);
      checkOutput("lw_no_proc_req", mif1.proc_req, 0);
      tick();
      applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
      checkOutput("ld_illegal_size", mis1, 1);
      checkOutput("ld_no_proc_req", mif1.proc_req, 0);
      tick();
      checkOutput("misalign_pulse", mis1, 0);
      checkOutput("misalign_no_proc_req", mif1.proc_req, 0);

      // Non-blocking instance: third load waits for the first response
      mif2.mem_rdy = 1;
      applyStimulusNb(1, 32'h10, 5'd1);
      #1 checkOutput("nb_l1_stall", stall2, 0);
      tick();
      applyStimulusNb(1, 32'h14, 5'd2);
      #1 checkOutput("nb_l2_stall", stall2, 0);
      tick();
      applyStimulusNb(1, 32'h18, 5'd3);
      #1 checkOutput("nb_l3_stall_a", stall2, 1);
      tick();
      checkOutput("nb_l3_stall_b", stall2, 1);
      tick();
      checkOutput("nb_l3_stall_c", stall2, 1);
      mif2.valid = 1; mif2.rdata = 32'h11111111;
      tick();
      mif2.valid = 0;
      checkOutput("nb_r1_valid", lv2, 1);
      checkOutput("nb_r1_data", ld2, 32'h11111111);
      checkOutput("nb_r1_dest", dest2, 5'd1);
      checkOutput("nb_l3_released", stall2, 0);
      tick();
      applyStimulusNb(0, 32'h0, 5'd0);
      checkOutput("nb_l3_proc_req", mif2.proc_req, 1);
      checkOutput("nb_l3_addr", mif2.addr, 32'h18);
      mif2.valid = 1; mif2.rdata = 32'h22222222;
      tick();
      checkOutput("nb_r2_data", ld2, 32'h22222222);
      checkOutput("nb_r2_dest", dest2, 5'd2);
      mif2.rdata = 32'h33333333;
      tick();
      mif2.valid = 0;
      checkOutput("nb_r3_valid", lv2, 1);
      checkOutput("nb_r3_data", ld2, 32'h33333333);
      checkOutput("nb_r3_dest", dest2, 5'd3);
      mif2.valid = 1; mif2.rdata = 32'h44444444;
      tick();
      mif2.valid = 0;
      checkOutput("nb_empty_valid_ignored", lv2, 0);
      checkOutput("nb_empty_data_hold", ld2, 32'h33333333);

      // Reset asserted while a load is being presented to memory
      mif1.mem_rdy = 0;
      applyStimulus(1, 0, 2'b10, 0, 32'h200, 32'h0, 5'd3);
      tick();
      applyStimulus(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0);
      checkOutput("rst_pre_proc_req", mif1.proc_req, 1);
      #2 rst = 1;
      #1;
      checkOutput("rst_proc_req", mif1.proc_req, 0);
      checkOutput("rst_addr", mif1.addr, 0);
      checkOutput("rst_be", mif1.be, 0);
      checkOutput("rst_load_data", ld1, 0);
      checkOutput("rst_stall", stall1, 0);
      tick();
      rst = 0;
      mif1.mem_rdy = 1;
      mif1.valid = 1; mif1.rdata = 32'h12345678;
      tick();
      mif1.valid = 0;
      checkOutput("rst_late_valid", lv1, 0);
      checkOutput("rst_late_proc_req", mif1.proc_req, 0);
      tick();
      checkOutput("rst_late_data", ld1, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
